// File: rtl/hpm_counter_bank.sv
// Bank of event-selectable performance counters with per-counter threshold interrupt.
// Define HPM_OVF_IRQ_EN to add sticky wrap flags (W1C at 0xFF) that also raise irq_o.
module hpm_counter_bank #(
    parameter int NumCounters = 6,
    parameter int NumEvents   = 32,
    parameter int CntW        = 64,
    parameter int IncW        = 2,
    parameter int XLEN        = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      debug_mode_i,
    input  logic [NumCounters-1:0]    inhibit_i,
    input  logic [NumEvents*IncW-1:0] events_i,
    input  logic [7:0]                addr_i,
    input  logic                      we_i,
    input  logic [XLEN-1:0]           data_i,
    output logic [XLEN-1:0]           data_o,
    output logic                      access_err_o,
    output logic                      irq_o
);

    localparam logic [63:0] LoMask = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                  : 64'h0000_0000_FFFF_FFFF;

    logic [CntW-1:0]    cnt_q   [NumCounters];
    logic [CntW-1:0]    cnt_d   [NumCounters];
    logic [CntW-1:0]    thr_q   [NumCounters];
    logic [CntW-1:0]    thr_d   [NumCounters];
    logic [4:0]         evsel_q [NumCounters];
    logic [4:0]         evsel_d [NumCounters];
    logic [IncW-1:0]    ev      [NumEvents];
    logic [NumCounters-1:0] ovf_set;

    logic [2:0]  region;
    logic [4:0]  idx;
    logic        idx_ok;
    logic        legal;
    logic        wr_en;
    logic [63:0] data_ext;
    logic [63:0] rd64;
    logic        irq_d;

    for (genvar e = 0; e < NumEvents; e++) begin : g_ev
        assign ev[e] = events_i[e*IncW +: IncW];
    end

    assign region   = addr_i[7:5];
    assign idx      = addr_i[4:0];
    assign idx_ok   = (int'(idx) < NumCounters);
    assign data_ext = 64'(data_i);
    assign wr_en    = we_i & legal;

    always_comb begin
        legal = 1'b0;
        case (region)
            3'd0, 3'd2, 3'd3: legal = idx_ok;
            3'd1, 3'd4:       legal = idx_ok && (XLEN == 32);
            default:          legal = 1'b0;
        endcase
`ifdef HPM_OVF_IRQ_EN
        if (addr_i == 8'hFF) legal = 1'b1;
`endif
    end

    assign access_err_o = ~legal;

`ifdef HPM_OVF_IRQ_EN
    logic [NumCounters-1:0] ovf_q;
    logic [NumCounters-1:0] ovf_clr;

    assign ovf_clr = (wr_en && addr_i == 8'hFF) ? data_i[NumCounters-1:0] : '0;

    // a wrap in the same cycle as a clear wins, so no event is lost
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ovf_q <= '0;
        else         ovf_q <= (ovf_q & ~ovf_clr) | ovf_set;
    end
`else
    logic unused_ovf;
    assign unused_ovf = ^ovf_set;
`endif

    always_comb begin
        logic [63:0] sel_cnt;
        logic [63:0] sel_thr;
        logic [4:0]  sel_evsel;
        sel_cnt   = '0;
        sel_thr   = '0;
        sel_evsel = '0;
        for (int i = 0; i < NumCounters; i++) begin
            if (int'(idx) == i) begin
                sel_cnt   = 64'(cnt_q[i]);
                sel_thr   = 64'(thr_q[i]);
                sel_evsel = evsel_q[i];
            end
        end
        rd64 = '0;
        if (legal) begin
            case (region)
                3'd0:    rd64 = sel_cnt & LoMask;
                3'd1:    rd64 = sel_cnt >> 32;
                3'd2:    rd64 = 64'(sel_evsel);
                3'd3:    rd64 = sel_thr & LoMask;
                3'd4:    rd64 = sel_thr >> 32;
                default: begin
`ifdef HPM_OVF_IRQ_EN
                    rd64 = 64'(ovf_q);
`endif
                end
            endcase
        end
    end

    assign data_o = rd64[XLEN-1:0];

    always_comb begin
        logic [IncW-1:0] inc;
        logic [CntW:0]   inc_ext;
        logic [CntW:0]   sum;
        logic [63:0]     cnt_cur;
        logic [63:0]     thr_cur;
        logic [63:0]     cnt_lo;
        logic [63:0]     cnt_hi;
        logic [63:0]     thr_lo;
        logic [63:0]     thr_hi;
        logic            hit;
        ovf_set = '0;
        for (int i = 0; i < NumCounters; i++) begin
            inc = '0;
            for (int e = 0; e < NumEvents; e++) begin
                if (evsel_q[i] != 5'd0 && int'(evsel_q[i]) == e) inc = ev[e];
            end
            inc_ext = '0;
            inc_ext[IncW-1:0] = inc;
            sum     = {1'b0, cnt_q[i]} + inc_ext;
            hit     = wr_en && (int'(idx) == i);
            cnt_cur = 64'(cnt_q[i]);
            thr_cur = 64'(thr_q[i]);
            cnt_lo  = (cnt_cur & ~LoMask) | (data_ext & LoMask);
            cnt_hi  = (cnt_cur & 64'h0000_0000_FFFF_FFFF) | (data_ext << 32);
            thr_lo  = (thr_cur & ~LoMask) | (data_ext & LoMask);
            thr_hi  = (thr_cur & 64'h0000_0000_FFFF_FFFF) | (data_ext << 32);

            cnt_d[i]   = cnt_q[i];
            evsel_d[i] = evsel_q[i];
            thr_d[i]   = thr_q[i];
            // software access to a counter drops that cycle's increment
            if (hit && region == 3'd0) begin
                cnt_d[i] = cnt_lo[CntW-1:0];
            end else if (hit && region == 3'd1) begin
                cnt_d[i] = cnt_hi[CntW-1:0];
            end else if (hit && region == 3'd2) begin
                cnt_d[i]   = '0;
                evsel_d[i] = data_i[4:0];
            end else if (!debug_mode_i && !inhibit_i[i]) begin
                cnt_d[i]   = sum[CntW-1:0];
                ovf_set[i] = sum[CntW];
            end
            if (hit && region == 3'd3) thr_d[i] = thr_lo[CntW-1:0];
            if (hit && region == 3'd4) thr_d[i] = thr_hi[CntW-1:0];
        end
    end

    always_comb begin
        irq_d = 1'b0;
        for (int i = 0; i < NumCounters; i++) begin
            if (thr_q[i] != '0 && cnt_q[i] >= thr_q[i]) irq_d = 1'b1;
        end
`ifdef HPM_OVF_IRQ_EN
        if (|ovf_q) irq_d = 1'b1;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumCounters; i++) begin
                cnt_q[i]   <= '0;
                thr_q[i]   <= '0;
                evsel_q[i] <= '0;
            end
            irq_o <= 1'b0;
        end else begin
            for (int i = 0; i < NumCounters; i++) begin
                cnt_q[i]   <= cnt_d[i];
                thr_q[i]   <= thr_d[i];
                evsel_q[i] <= evsel_d[i];
            end
            irq_o <= irq_d;
        end
    end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Self-checking bench for hpm_counter_bank: directed scenarios plus a randomized run
// against an array-based reference model. Overflow checks follow HPM_OVF_IRQ_EN.
module tb_hpm_counter_bank;

    localparam int NC = 6;
    localparam int NE = 32;
    localparam int IW = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          debug_mode_i;
    logic [NC-1:0] inhibit_i;
    logic [NE*IW-1:0] events_i;
    logic [7:0]    addr_i;
    logic          we_i;
    logic [63:0]   data_i;
    logic [63:0]   data_o;
    logic          access_err_o;
    logic          irq_o;

    hpm_counter_bank #(
        .NumCounters(NC), .NumEvents(NE), .CntW(64), .IncW(IW), .XLEN(64)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .debug_mode_i(debug_mode_i),
        .inhibit_i(inhibit_i), .events_i(events_i), .addr_i(addr_i),
        .we_i(we_i), .data_i(data_i), .data_o(data_o),
        .access_err_o(access_err_o), .irq_o(irq_o)
    );

    always #20 clk_i = ~clk_i;

    logic [63:0]   m_cnt   [NC];
    logic [4:0]    m_evsel [NC];
    logic [63:0]   m_thr   [NC];
    logic [NC-1:0] m_ovf;
    logic          m_irq;
    logic [1:0]    ev_a    [NE];

    int tests_run = 0;
    int fails     = 0;

    function automatic bit m_legal(input logic [7:0] a);
        if (a == 8'hFF) begin
`ifdef HPM_OVF_IRQ_EN
            return 1'b1;
`else
            return 1'b0;
`endif
        end
        if (int'(a[4:0]) >= NC) return 1'b0;
        case (a[7:5])
            3'd0, 3'd2, 3'd3: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_cnt[i]   = '0;
            m_evsel[i] = '0;
            m_thr[i]   = '0;
        end
        m_ovf = '0;
        m_irq = 1'b0;
    endtask

    task automatic drive_events();
        for (int e = 0; e < NE; e++) events_i[e*IW +: IW] = ev_a[e];
    endtask

    task automatic rand_events();
        for (int e = 0; e < NE; e++) ev_a[e] = 2'($urandom_range(0, 3));
    endtask

    task automatic rd(input logic [7:0] a, output logic [63:0] d, output logic e);
        addr_i = a;
        we_i   = 1'b0;
        #1;
        d = data_o;
        e = access_err_o;
    endtask

    // Advance one clock; the model consumes the inputs as they stand at the edge.
    task automatic tick();
        logic [63:0]   n_cnt [NC];
        logic [4:0]    n_ev  [NC];
        logic [63:0]   n_thr [NC];
        logic [NC-1:0] n_ovf;
        bit cond, legal, touched;
        cond = 1'b0;
        for (int i = 0; i < NC; i++)
            if (m_thr[i] != 64'd0 && m_cnt[i] >= m_thr[i]) cond = 1'b1;
`ifdef HPM_OVF_IRQ_EN
        if (m_ovf != '0) cond = 1'b1;
`endif
        legal = m_legal(addr_i);
        n_ovf = m_ovf;
        if (we_i && legal && addr_i == 8'hFF) n_ovf = m_ovf & ~data_i[NC-1:0];
        for (int i = 0; i < NC; i++) begin
            n_cnt[i] = m_cnt[i];
            n_ev[i]  = m_evsel[i];
            n_thr[i] = m_thr[i];
            touched  = 1'b0;
            if (we_i && legal) begin
                if (int'(addr_i) == i) begin
                    n_cnt[i] = data_i;
                    touched  = 1'b1;
                end
                if (int'(addr_i) == 32'h40 + i) begin
                    n_ev[i]  = data_i[4:0];
                    n_cnt[i] = 64'd0;
                    touched  = 1'b1;
                end
                if (int'(addr_i) == 32'h60 + i) n_thr[i] = data_i;
            end
            if (!touched && !debug_mode_i && !inhibit_i[i] &&
                m_evsel[i] != 5'd0 && int'(m_evsel[i]) < NE) begin
                n_cnt[i] = m_cnt[i] + 64'(ev_a[m_evsel[i]]);
                if (n_cnt[i] < m_cnt[i]) n_ovf[i] = 1'b1;
            end
        end
        @(posedge clk_i);
        #1;
        for (int i = 0; i < NC; i++) begin
            m_cnt[i]   = n_cnt[i];
            m_evsel[i] = n_ev[i];
            m_thr[i]   = n_thr[i];
        end
        m_ovf = n_ovf;
        m_irq = cond;
    endtask

    task automatic test_reset();
        logic [63:0] d;
        logic e;
        rst_ni = 1'b0; debug_mode_i = 1'b0; inhibit_i = '0; events_i = '0;
        addr_i = 8'h00; we_i = 1'b0; data_i = '0;
        for (int k = 0; k < NE; k++) ev_a[k] = 2'd0;
        model_reset();
        #5;
        rd(8'h00, d, e);
        tests_run++; if (d !== 64'd0) begin fails++; $display("FAIL reset_data: got %h expected 0", d); end
        tests_run++; if (e !== 1'b0)  begin fails++; $display("FAIL reset_err: got %b expected 0", e); end
        tests_run++; if (irq_o !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        for (int i = 0; i < NC; i++) begin
            rd(8'(i), d, e);
            tests_run++;
            if (d !== m_cnt[i]) begin fails++; $display("FAIL reset_cnt%0d: got %h expected %h", i, d, m_cnt[i]); end
        end
    endtask

    task automatic test_count();
        logic [63:0] d;
        logic e;
        rand_events(); ev_a[3] = 2'd2; drive_events();
        we_i = 1'b1; addr_i = 8'h40; data_i = 64'd3;
        tick();
        we_i = 1'b0;
        repeat (10) begin
            rand_events(); ev_a[3] = 2'd2; drive_events();
            tick();
        end
        rd(8'h00, d, e);
        tests_run++; if (d !== 64'd20) begin fails++; $display("FAIL count_20: got %0d expected 20", d); end
        tests_run++; if (d !== m_cnt[0]) begin fails++; $display("FAIL count_model: got %0d expected %0d", d, m_cnt[0]); end
        inhibit_i = 6'b000001;
        we_i = 1'b1; addr_i = 8'h40; data_i = 64'd3;
        tick();
        we_i = 1'b0;
        repeat (10) begin
            rand_events(); ev_a[3] = 2'd2; drive_events();
            tick();
        end
        rd(8'h00, d, e);
        tests_run++; if (d !== 64'd0) begin fails++; $display("FAIL inhibit: got %0d expected 0", d); end
        inhibit_i = '0;
    endtask

    task automatic test_wrap();
        logic [63:0] d;
        logic e;
        ev_a[5] = 2'd0; drive_events();
        we_i = 1'b1; addr_i = 8'h41; data_i = 64'd5;
        tick();
        ev_a[5] = 2'd2; drive_events();
        we_i = 1'b1; addr_i = 8'h01; data_i = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        we_i = 1'b0;
        tick();
        ev_a[5] = 2'd0; drive_events();
        rd(8'h01, d, e);
        tests_run++; if (d !== 64'd1) begin fails++; $display("FAIL wrap_cnt: got %h expected 1", d); end
        tests_run++; if (d !== m_cnt[1]) begin fails++; $display("FAIL wrap_model: got %h expected %h", d, m_cnt[1]); end
`ifdef HPM_OVF_IRQ_EN
        rd(8'hFF, d, e);
        tests_run++; if (d !== 64'h2 || e !== 1'b0) begin fails++; $display("FAIL ovf_flag: got %h err %b expected 2 err 0", d, e); end
        tick();
        tests_run++; if (irq_o !== 1'b1) begin fails++; $display("FAIL ovf_irq: got %b expected 1", irq_o); end
        we_i = 1'b1; addr_i = 8'hFF; data_i = 64'h2;
        tick();
        we_i = 1'b0;
        tests_run++; if (irq_o !== m_irq) begin fails++; $display("FAIL ovf_irq_hold: got %b expected %b", irq_o, m_irq); end
        tick();
        tests_run++; if (irq_o !== 1'b0) begin fails++; $display("FAIL ovf_w1c_irq: got %b expected 0", irq_o); end
        rd(8'hFF, d, e);
        tests_run++; if (d !== 64'h0) begin fails++; $display("FAIL ovf_w1c: got %h expected 0", d); end
`else
        rd(8'hFF, d, e);
        tests_run++; if (e !== 1'b1 || d !== 64'd0) begin fails++; $display("FAIL ovf_absent: got %h err %b expected 0 err 1", d, e); end
        tick();
        tests_run++; if (irq_o !== 1'b0) begin fails++; $display("FAIL wrap_noirq: got %b expected 0", irq_o); end
`endif
    endtask

    task automatic test_threshold();
        logic [63:0] d;
        logic e;
        ev_a[7] = 2'd1; drive_events();
        we_i = 1'b1; addr_i = 8'h62; data_i = 64'd5;
        tick();
        we_i = 1'b1; addr_i = 8'h42; data_i = 64'd7;
        tick();
        we_i = 1'b0;
        for (int k = 0; k < 20 && m_cnt[2] != 64'd5; k++) tick();
        rd(8'h02, d, e);
        tests_run++; if (d !== 64'd5) begin fails++; $display("FAIL thr_cnt: got %0d expected 5", d); end
        tests_run++; if (irq_o !== 1'b0) begin fails++; $display("FAIL thr_irq_early: got %b expected 0", irq_o); end
        tick();
        tests_run++; if (irq_o !== 1'b1) begin fails++; $display("FAIL thr_irq_rise: got %b expected 1", irq_o); end
        ev_a[7] = 2'd0; drive_events();
        we_i = 1'b1; addr_i = 8'h02; data_i = 64'd0;
        tick();
        we_i = 1'b0;
        tests_run++; if (irq_o !== m_irq) begin fails++; $display("FAIL thr_irq_hold: got %b expected %b", irq_o, m_irq); end
        tick();
        tests_run++; if (irq_o !== 1'b0) begin fails++; $display("FAIL thr_irq_fall: got %b expected 0", irq_o); end
        we_i = 1'b1; addr_i = 8'h62; data_i = 64'd0;
        tick();
        we_i = 1'b0;
    endtask

    task automatic test_write_priority();
        logic [63:0] d, snap;
        logic e;
        rand_events(); ev_a[3] = 2'd1; ev_a[7] = 2'd1; drive_events();
        snap = m_cnt[2];
        we_i = 1'b1; addr_i = 8'h00; data_i = 64'd100;
        tick();
        we_i = 1'b0;
        rd(8'h00, d, e);
        tests_run++; if (d !== 64'd100) begin fails++; $display("FAIL wr_prio: got %0d expected 100", d); end
        rd(8'h02, d, e);
        tests_run++; if (d !== snap + 64'd1) begin fails++; $display("FAIL wr_other: got %0d expected %0d", d, snap + 64'd1); end
    endtask

    task automatic test_access_err();
        logic [63:0] d;
        logic e;
        logic [7:0] bad [9];
        bad = '{8'h20, 8'h06, 8'h80, 8'h25, 8'h46, 8'h67, 8'hA0, 8'hC0, 8'h1F};
        for (int k = 0; k < 9; k++) begin
            rd(bad[k], d, e);
            tests_run++;
            if (e !== 1'b1 || d !== 64'd0) begin
                fails++; $display("FAIL acc_err_%h: got %h err %b expected 0 err 1", bad[k], d, e);
            end
        end
        rd(8'h45, d, e);
        tests_run++; if (e !== 1'b0) begin fails++; $display("FAIL acc_ok_45: got err %b expected 0", e); end
        we_i = 1'b1; addr_i = 8'h06; data_i = {$urandom, $urandom};
        tick();
        we_i = 1'b0;
        for (int i = 0; i < NC; i++) begin
            rd(8'(i), d, e);
            tests_run++;
            if (d !== m_cnt[i]) begin fails++; $display("FAIL acc_ignored_cnt%0d: got %h expected %h", i, d, m_cnt[i]); end
        end
    endtask

    task automatic test_debug();
        logic [63:0] d, snap [NC];
        logic e;
        for (int i = 0; i < NC; i++) snap[i] = m_cnt[i];
        debug_mode_i = 1'b1;
        repeat (8) begin
            rand_events(); drive_events();
            tick();
        end
        debug_mode_i = 1'b0;
        for (int i = 0; i < NC; i++) begin
            rd(8'(i), d, e);
            tests_run++;
            if (d !== snap[i]) begin fails++; $display("FAIL debug_cnt%0d: got %h expected %h", i, d, snap[i]); end
        end
    endtask

    task automatic test_random();
        logic [63:0] d;
        logic e;
        logic [2:0] reg_sel [10];
        reg_sel = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd3, 3'd3, 3'd1, 3'd4, 3'd7, 3'd7};
        for (int c = 0; c < 300; c++) begin
            int r;
            rand_events(); drive_events();
            inhibit_i    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : '0;
            debug_mode_i = ($urandom_range(0, 15) == 0);
            we_i         = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 10);
            if (r == 10)                addr_i = 8'($urandom);
            else if (reg_sel[r] == 3'd7) addr_i = 8'hFF;
            else                         addr_i = {reg_sel[r], 5'($urandom_range(0, 7))};
            case ($urandom_range(0, 3))
                0:       data_i = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                1:       data_i = 64'($urandom_range(0, 60));
                default: data_i = {$urandom, $urandom};
            endcase
            tick();
            debug_mode_i = 1'b0;
            for (int i = 0; i < NC; i++) begin
                rd(8'(i), d, e);
                tests_run++;
                if (d !== m_cnt[i]) begin fails++; $display("FAIL rnd_cnt%0d c%0d: got %h expected %h", i, c, d, m_cnt[i]); end
            end
            tests_run++;
            if (irq_o !== m_irq) begin fails++; $display("FAIL rnd_irq c%0d: got %b expected %b", c, irq_o, m_irq); end
            if (c % 8 == 0) begin
                for (int i = 0; i < NC; i++) begin
                    rd(8'(8'h40 + i), d, e);
                    tests_run++;
                    if (d !== 64'(m_evsel[i])) begin fails++; $display("FAIL rnd_evsel%0d: got %h expected %h", i, d, m_evsel[i]); end
                    rd(8'(8'h60 + i), d, e);
                    tests_run++;
                    if (d !== m_thr[i]) begin fails++; $display("FAIL rnd_thr%0d: got %h expected %h", i, d, m_thr[i]); end
                end
`ifdef HPM_OVF_IRQ_EN
                rd(8'hFF, d, e);
                tests_run++;
                if (d !== 64'(m_ovf)) begin fails++; $display("FAIL rnd_ovf: got %h expected %h", d, m_ovf); end
`endif
            end
        end
        inhibit_i = '0;
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        logic e;
        for (int i = 0; i < 3; i++) begin
            we_i = 1'b1; addr_i = 8'(8'h40 + i); data_i = 64'(i + 1);
            tick();
        end
        we_i = 1'b0;
        repeat (4) begin
            rand_events(); drive_events();
            tick();
        end
        we_i = 1'b1; addr_i = 8'h43; data_i = 64'd9;
        rst_ni = 1'b0;
        #2;
        model_reset();
        for (int i = 0; i < NC; i++) begin
            rd(8'(i), d, e);
            tests_run++;
            if (d !== 64'd0) begin fails++; $display("FAIL rstmid_cnt%0d: got %h expected 0", i, d); end
            rd(8'(8'h40 + i), d, e);
            tests_run++;
            if (d !== 64'd0) begin fails++; $display("FAIL rstmid_evsel%0d: got %h expected 0", i, d); end
            rd(8'(8'h60 + i), d, e);
            tests_run++;
            if (d !== 64'd0) begin fails++; $display("FAIL rstmid_thr%0d: got %h expected 0", i, d); end
        end
        tests_run++; if (irq_o !== 1'b0) begin fails++; $display("FAIL rstmid_irq: got %b expected 0", irq_o); end
        rst_ni = 1'b1;
        tick();
        for (int i = 0; i < NC; i++) begin
            rd(8'(i), d, e);
            tests_run++;
            if (d !== m_cnt[i]) begin fails++; $display("FAIL rstpost_cnt%0d: got %h expected %h", i, d, m_cnt[i]); end
        end
        tests_run++; if (irq_o !== 1'b0) begin fails++; $display("FAIL rstpost_irq: got %b expected 0", irq_o); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_threshold();
        test_write_priority();
        test_access_err();
        test_debug();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/hpm_counter_bank.md
HPM_COUNTER_BANK -- requirements
Module: hpm_counter_bank

Interface
REQ-001 SHALL have parameter NumCounters, default 6, number of programmable counters (legal range 1..29).
REQ-002 SHALL have parameter NumEvents, default 32, number of event sources; index 0 is reserved as "no event".
REQ-003 SHALL have parameter CntW, default 64, counter width in bits (legal range 33..64).
REQ-004 SHALL have parameter IncW, default 2, width of the per-event increment (supports multi-commit counting).
REQ-005 SHALL have parameter XLEN, default 64, register data width (legal values 32 or 64).
REQ-006 SHALL have ports, in this order:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous, active-low reset.
- debug_mode_i  input  1  when high, all counting is suspended.
- inhibit_i  input  NumCounters  per-counter count inhibit.
- events_i  input  NumEvents x IncW  per-event increment amount for this cycle.
- addr_i  input  8  register address.
- we_i  input  1  write enable.
- data_i  input  XLEN  write data.
- data_o  output  XLEN  combinational read data.
- access_err_o  output  1  combinational; high for an illegal access.
- irq_o  output  1  registered interrupt request.

Function
REQ-007 SHALL implement the following address map, with i = 0..NumCounters-1:
- 0x00+i: counter[i], low XLEN bits.
- 0x20+i: counter[i], bits [CntW-1:32]; legal only when XLEN=32.
- 0x40+i: evsel[i]; 5 bits wide, upper bits read as 0.
- 0x60+i: threshold[i], low XLEN bits.
- 0x80+i: threshold[i], high bits; legal only when XLEN=32.
- 0xFF: overflow status (see Configuration).
REQ-008 SHALL assert access_err_o, return data_o=0 and ignore writes for: unmapped addresses, i >= NumCounters, and high-half addresses when XLEN=64.
REQ-009 SHALL, each cycle, add events_i[evsel[i]] (zero-extended) to counter[i] when all of the following hold: debug_mode_i=0, inhibit_i[i]=0, 0 < evsel[i] < NumEvents.
REQ-010 SHALL add nothing when evsel[i] is 0 or evsel[i] >= NumEvents.
REQ-011 SHALL compute counter arithmetic modulo 2^CntW, with wrap-around to low values.
REQ-012 SHALL give a same-cycle write to any part of counter[i] priority over that counter's increment; the increment of that cycle is dropped. Other counters keep counting.
REQ-013 SHALL, on a write to evsel[i], clear counter[i] to 0 on the next edge.
REQ-014 SHALL make register writes take effect at the next clock edge; reads return the pre-write value in the write cycle.
REQ-015 SHALL set irq_o one cycle after any i satisfies threshold[i] != 0 and counter[i] >= threshold[i] (unsigned comparison), or after an enabled overflow condition.
REQ-016 SHALL clear irq_o one cycle after no condition remains (level-sensitive, not sticky).

Reset
REQ-017 SHALL, on rst_ni low, asynchronously clear all counters, evsel, thresholds, overflow bits and irq_o to 0.
REQ-018 SHALL keep data_o and access_err_o purely combinational from addr_i and state, so both are 0 for address 0x00 during reset.
REQ-019 SHALL discard any write or increment in the cycle reset asserts; a counter reset mid-increment SHALL read 0.

Configuration
REQ-020 SHALL, when macro HPM_OVF_IRQ_EN is defined:
- set a sticky ovf[i] when counter[i] wraps by increment (not by software write);
- read 0xFF as ovf in bits [NumCounters-1:0];
- treat a write to 0xFF as write-1-to-clear;
- make any set ovf bit assert irq_o per REQ-015;
- let a wrap and a clear in the same cycle leave ovf[i] set.
REQ-021 SHALL, when HPM_OVF_IRQ_EN is undefined: omit the ovf storage, make address 0xFF illegal per REQ-008, and take no interrupt contribution from wrap.

Verification
REQ-022 SHALL cover: evsel[0]=3, events_i[3]=2 for 10 cycles -> counter[0]=20; the same with inhibit_i[0]=1 -> counter[0]=0.
REQ-023 SHALL cover: counter[1] at 2^CntW-1, increment 2 -> counter[1]=1, and with macro defined ovf[1]=1 and irq_o=1 next cycle; W1C of 0x02 at 0xFF -> irq_o=0 one cycle later.
REQ-024 SHALL cover: threshold[2]=5, counting 1 per cycle from 0 -> irq_o rises the cycle after counter[2]=5; writing counter[2]=0 -> irq_o falls.
REQ-025 SHALL cover: write counter[0]=100 while events_i active -> counter[0]=100 next cycle, not 101; a counter not being written increments normally.
REQ-026 SHALL cover: XLEN=64, read 0x20 -> access_err_o=1, data_o=0; NumCounters=6, read 0x06 -> access_err_o=1.
REQ-027 SHALL cover: debug_mode_i=1 with active events for 8 cycles -> all counters unchanged; rst_ni pulsed mid-count -> all registers 0 and irq_o=0.
